// File: rtl/piso_serializer_if.sv
// Load-side handshake bundle for piso_serializer: producer drives a word with
// valid, serializer answers with ready.
interface piso_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] load_data;
    logic         load_valid;
    logic         load_ready;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding buffer; emits one
// bit per bit_en pulse with a frame strobe and a first-bit strobe.
module piso_serializer #(
    parameter int N         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    piso_serializer_if.slave ld,
    input  logic             bit_en,
    output logic             sdata,
    output logic             sframe,
    output logic             sfirst,
    output logic             busy
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [N-1:0]     hb;
    logic             hb_full;
    logic [N-1:0]     sr;
    logic [N-1:0]     sr_next;
    logic [CNT_W-1:0] cnt;
    logic             load_sr;

    function automatic logic lead_bit(input logic [N-1:0] w);
        return LSB_FIRST ? w[0] : w[N-1];
    endfunction

    function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign sr_next      = shift_word(sr);
    assign ld.load_ready = !hb_full;
    assign busy         = sframe | hb_full;

    // The buffered word moves into the shifter from IDLE, or straight after the
    // last bit of the current word so consecutive frames have no gap.
    assign load_sr = bit_en && hb_full && ((state == IDLE) || (cnt == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hb      <= '0;
            hb_full <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            sdata   <= 1'b0;
            sframe  <= 1'b0;
            sfirst  <= 1'b0;
        end else begin
            if (load_sr) begin
                sr      <= hb;
                hb_full <= 1'b0;
                cnt     <= CNT_W'(N - 1);
                sdata   <= lead_bit(hb);
                sframe  <= 1'b1;
                sfirst  <= 1'b1;
                state   <= SHIFT;
            end else if (bit_en && (state == SHIFT)) begin
                if (cnt != '0) begin
                    sr     <= sr_next;
                    cnt    <= cnt - 1'b1;
                    sdata  <= lead_bit(sr_next);
                    sfirst <= 1'b0;
                end else begin
                    state  <= IDLE;
                    sdata  <= 1'b0;
                    sframe <= 1'b0;
                    sfirst <= 1'b0;
                end
            end

            // Accept only when empty, so it can never collide with the transfer above.
            if (ld.load_valid && !hb_full) begin
                hb      <= ld.load_data;
                hb_full <= 1'b1;
            end
        end
    end
endmodule
